// File: rtl/cu_branch_seq.sv
// Multicycle sequencer for LEGv8 branch-class instructions (B, BL, BR, CBZ, CBNZ, B.cond).
// Latches the instruction, emits one datapath control word per cycle and pulses done on the last one.
module cu_branch_seq #(
  parameter int CUL    = 35,
  parameter int LR_IDX = 30,
  parameter int ZR_IDX = 31
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic [31:0]    IR,
  input  logic [3:0]     status,
  output logic [CUL:0]   controlWord,
  output logic [2:0]     k_mux,
  output logic           busy,
  output logic           done,
  output logic           taken,
  output logic           illegal,
  output logic [3:0]     state
);

  localparam logic [3:0] S_IDLE = 4'b0000;
  localparam logic [3:0] S_EX0  = 4'b0001;
  localparam logic [3:0] S_EX1  = 4'b0010;
  localparam logic [3:0] S_ERR  = 4'b1000;

  // Handshake: start is sampled only in IDLE or in a cycle with done=1;
  // at any other time it is ignored and ir_q holds.

  logic [3:0]  state_q, state_d;
  logic [31:0] ir_q, ir_d;

  logic is_b, is_bl, is_bcond, is_cbz, is_cbnz, is_br, is_legal, cond_ok;
  logic flag_n, flag_z, flag_c, flag_v;

  logic [4:0] fs, sa, sb, da;
  logic       w_reg, status_load, pc_sel;
  logic [1:0] data_tri_sel, pc_fs;
  logic [35:0] cw;

  assign {flag_n, flag_z, flag_c, flag_v} = status;

  assign is_b     = (ir_q[31:26] == 6'b000101);
  assign is_bl    = (ir_q[31:26] == 6'b100101);
  assign is_bcond = (ir_q[31:24] == 8'b01010100) && !ir_q[4];
  assign is_cbz   = (ir_q[31:24] == 8'b10110100);
  assign is_cbnz  = (ir_q[31:24] == 8'b10110101);
  assign is_br    = (ir_q[31:10] == 22'b1101011000011111000000) && (ir_q[4:0] == 5'd0);
  assign is_legal = is_b | is_bl | is_bcond | is_cbz | is_cbnz | is_br;

  // ARM condition evaluation: odd codes invert the even base, except 1111 (always).
  always_comb begin
    logic base;
    case (ir_q[3:1])
      3'b000:  base = flag_z;
      3'b001:  base = flag_c;
      3'b010:  base = flag_n;
      3'b011:  base = flag_v;
      3'b100:  base = flag_c & ~flag_z;
      3'b101:  base = (flag_n == flag_v);
      3'b110:  base = ~flag_z & (flag_n == flag_v);
      default: base = 1'b1;
    endcase
    cond_ok = (ir_q[0] && ir_q[3:1] != 3'b111) ? ~base : base;
  end

  always_comb begin
    state_d      = state_q;
    ir_d         = ir_q;
    fs           = 5'd0;
    sa           = 5'd0;
    sb           = 5'd0;
    da           = 5'd0;
    w_reg        = 1'b0;
    status_load  = 1'b0;
    pc_sel       = 1'b0;
    data_tri_sel = 2'b00;
    pc_fs        = 2'b00;
    k_mux        = 3'b000;
    done         = 1'b0;
    taken        = 1'b0;
    illegal      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_EX0;
          ir_d    = IR;
        end
      end
      S_EX0: begin
        if (!is_legal) begin
          illegal = 1'b1;
          state_d = S_ERR;
        end else if (is_b) begin
          pc_fs = 2'b10;
          k_mux = 3'b011;
          taken = 1'b1;
          done  = 1'b1;
        end else if (is_bcond) begin
          done = 1'b1;
          if (cond_ok) begin
            pc_fs = 2'b10;
            k_mux = 3'b100;
            taken = 1'b1;
          end else begin
            pc_fs = 2'b01;
          end
        end else if (is_br) begin
          sa     = ir_q[9:5];
          fs     = 5'b00100;
          pc_sel = 1'b1;
          pc_fs  = 2'b11;
          taken  = 1'b1;
          done   = 1'b1;
        end else if (is_bl) begin
          da           = 5'(LR_IDX);
          w_reg        = 1'b1;
          data_tri_sel = 2'b10;
          state_d      = S_EX1;
        end else begin
          fs          = 5'b00100;
          sa          = 5'(ZR_IDX);
          sb          = ir_q[4:0];
          status_load = 1'b1;
          state_d     = S_EX1;
        end
      end
      S_EX1: begin
        done = 1'b1;
        if (is_bl) begin
          pc_fs = 2'b10;
          k_mux = 3'b011;
          taken = 1'b1;
        end else begin
          taken = is_cbz ? flag_z : ~flag_z;
          if (taken) begin
            pc_fs = 2'b10;
            k_mux = 3'b100;
          end else begin
            pc_fs = 2'b01;
          end
        end
      end
      S_ERR: begin
        pc_fs   = 2'b01;
        illegal = 1'b1;
        done    = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
    if (done) begin
      state_d = start ? S_EX0 : S_IDLE;
      if (start) ir_d = IR;
    end
  end

  assign cw = {fs, sa, sb, da, w_reg, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, status_load,
               2'b00, 1'b0, data_tri_sel, pc_sel, pc_fs};

  always_comb begin
    controlWord       = '0;
    controlWord[35:0] = cw;
  end

  assign busy  = (state_q != S_IDLE);
  assign state = state_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      ir_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

endmodule

// File: tb/tb_cu_branch_seq.sv
// Directed bench for cu_branch_seq: each scenario task drives vectors and checks hand-computed outputs.
module tb_cu_branch_seq;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic [31:0] IR = 32'd0;
  logic [3:0]  status = 4'd0;
  logic [35:0] controlWord;
  logic [2:0]  k_mux;
  logic        busy, done, taken, illegal;
  logic [3:0]  state;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] IR_B    = 32'h14000004;
  localparam logic [31:0] IR_BL   = 32'h94000010;
  localparam logic [31:0] IR_CBZ  = 32'hB4000043;
  localparam logic [31:0] IR_CBNZ = 32'hB5000043;
  localparam logic [31:0] IR_BR   = 32'hD61F00A0;
  localparam logic [31:0] IR_ADD  = 32'h8B020020;

  cu_branch_seq #(.CUL(35), .LR_IDX(30), .ZR_IDX(31)) dut (
    .clock(clock), .reset(reset), .start(start), .IR(IR), .status(status),
    .controlWord(controlWord), .k_mux(k_mux), .busy(busy), .done(done),
    .taken(taken), .illegal(illegal), .state(state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Independent ARM condition table; status = {N,Z,C,V}.
  function automatic logic cond_model(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return !z;
      4'h2: return cf;
      4'h3: return !cf;
      4'h4: return n;
      4'h5: return !n;
      4'h6: return v;
      4'h7: return !v;
      4'h8: return cf && !z;
      4'h9: return !cf || z;
      4'hA: return n == v;
      4'hB: return n != v;
      4'hC: return !z && (n == v);
      4'hD: return z || (n != v);
      default: return 1'b1;
    endcase
  endfunction

  task automatic test_reset();
    #2;
    checks++;
    if ({controlWord, k_mux, busy, done, taken, illegal, state} !== 47'd0) begin
      errors++;
      $display("FAIL reset_outputs: got cw=%h k=%b busy=%b done=%b taken=%b ill=%b st=%b, want all 0",
               controlWord, k_mux, busy, done, taken, illegal, state);
    end
    tick();
    reset = 1'b0;
    tick();
    checks++;
    if (state !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: got state=%b busy=%b, want 0000 0", state, busy);
    end
  endtask

  task automatic test_b();
    IR = IR_B; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (state !== 4'b0001 || controlWord !== 36'h2 || k_mux !== 3'b011 ||
        taken !== 1'b1 || done !== 1'b1 || busy !== 1'b1 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL b_ex0: got st=%b cw=%h k=%b t=%b d=%b busy=%b ill=%b, want 0001 2 011 1 1 1 0",
               state, controlWord, k_mux, taken, done, busy, illegal);
    end
    tick();
    checks++;
    if (busy !== 1'b0 || state !== 4'b0000) begin
      errors++;
      $display("FAIL b_busy_one_cycle: got busy=%b st=%b, want 0 0000", busy, state);
    end
  endtask

  task automatic test_bl();
    IR = IR_BL; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (state !== 4'b0001 || controlWord !== 36'h0001E8010 || k_mux !== 3'b000 || done !== 1'b0) begin
      errors++;
      $display("FAIL bl_ex0: got st=%b cw=%h k=%b d=%b, want 0001 0001e8010 000 0",
               state, controlWord, k_mux, done);
    end
    tick();
    checks++;
    if (state !== 4'b0010 || controlWord !== 36'h2 || k_mux !== 3'b011 || done !== 1'b1 || taken !== 1'b1) begin
      errors++;
      $display("FAIL bl_ex1: got st=%b cw=%h k=%b d=%b t=%b, want 0010 2 011 1 1",
               state, controlWord, k_mux, done, taken);
    end
    tick();
  endtask

  task automatic test_cbz_cbnz();
    status = 4'b0100;
    IR = IR_CBZ; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (controlWord !== 36'h27C600100 || done !== 1'b0 || state !== 4'b0001) begin
      errors++;
      $display("FAIL cbz_ex0: got cw=%h d=%b st=%b, want 27c600100 0 0001", controlWord, done, state);
    end
    tick();
    checks++;
    if (taken !== 1'b1 || controlWord !== 36'h2 || k_mux !== 3'b100 || done !== 1'b1) begin
      errors++;
      $display("FAIL cbz_ex1_taken: got t=%b cw=%h k=%b d=%b, want 1 2 100 1", taken, controlWord, k_mux, done);
    end
    tick();
    IR = IR_CBNZ; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (controlWord !== 36'h27C600100) begin
      errors++;
      $display("FAIL cbnz_ex0: got cw=%h, want 27c600100", controlWord);
    end
    tick();
    checks++;
    if (taken !== 1'b0 || controlWord !== 36'h1 || k_mux !== 3'b000 || done !== 1'b1) begin
      errors++;
      $display("FAIL cbnz_ex1_not_taken: got t=%b cw=%h k=%b d=%b, want 0 1 000 1", taken, controlWord, k_mux, done);
    end
    status = 4'b0000;
    #1;
    checks++;
    if (taken !== 1'b1 || controlWord !== 36'h2 || k_mux !== 3'b100) begin
      errors++;
      $display("FAIL cbnz_ex1_taken_z0: got t=%b cw=%h k=%b, want 1 2 100", taken, controlWord, k_mux);
    end
    tick();
  endtask

  task automatic test_br();
    IR = IR_BR; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (controlWord !== 36'h214000007 || taken !== 1'b1 || done !== 1'b1 || k_mux !== 3'b000) begin
      errors++;
      $display("FAIL br_ex0: got cw=%h t=%b d=%b k=%b, want 214000007 1 1 000", controlWord, taken, done, k_mux);
    end
    tick();
  endtask

  task automatic test_bcond_sweep();
    int bad = 0;
    for (int c = 0; c < 16; c++) begin
      for (int f = 0; f < 16; f++) begin
        logic exp_t;
        IR = 32'h54000040 | 32'(c);
        status = 4'(f);
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_t = cond_model(4'(c), 4'(f));
        checks++;
        if (taken !== exp_t || done !== 1'b1 ||
            controlWord !== (exp_t ? 36'h2 : 36'h1) || k_mux !== (exp_t ? 3'b100 : 3'b000)) begin
          errors++;
          bad++;
          if (bad < 10)
            $display("FAIL bcond c=%h f=%b: got t=%b cw=%h k=%b d=%b, want t=%b", c, f,
                     taken, controlWord, k_mux, done, exp_t);
        end
        tick();
      end
    end
    status = 4'b0000;
  endtask

  task automatic test_illegal();
    IR = IR_ADD; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (state !== 4'b0001 || illegal !== 1'b1 || done !== 1'b0 || controlWord !== 36'h0) begin
      errors++;
      $display("FAIL illegal_ex0: got st=%b ill=%b d=%b cw=%h, want 0001 1 0 0", state, illegal, done, controlWord);
    end
    tick();
    checks++;
    if (state !== 4'b1000 || illegal !== 1'b1 || done !== 1'b1 || controlWord !== 36'h1 || taken !== 1'b0) begin
      errors++;
      $display("FAIL illegal_err: got st=%b ill=%b d=%b cw=%h t=%b, want 1000 1 1 1 0",
               state, illegal, done, controlWord, taken);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    IR = IR_BL; start = 1'b1;
    tick();
    IR = IR_ADD;
    tick();
    checks++;
    if (state !== 4'b0010 || controlWord !== 36'h2 || k_mux !== 3'b011 || done !== 1'b1) begin
      errors++;
      $display("FAIL b2b_bl_ex1: got st=%b cw=%h k=%b d=%b, want 0010 2 011 1", state, controlWord, k_mux, done);
    end
    IR = IR_B;
    tick();
    checks++;
    if (state !== 4'b0001 || controlWord !== 36'h2 || k_mux !== 3'b011 || done !== 1'b1 || taken !== 1'b1) begin
      errors++;
      $display("FAIL b2b_b_ex0: got st=%b cw=%h k=%b d=%b t=%b, want 0001 2 011 1 1",
               state, controlWord, k_mux, done, taken);
    end
    start = 1'b0;
    tick();
    checks++;
    if (state !== 4'b0000) begin
      errors++;
      $display("FAIL b2b_idle: got st=%b, want 0000", state);
    end
  endtask

  task automatic test_reset_mid_cbz();
    status = 4'b0100;
    IR = IR_CBZ; start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({controlWord, k_mux, busy, done, taken, illegal, state} !== 47'd0) begin
      errors++;
      $display("FAIL reset_mid_cbz: got cw=%h k=%b busy=%b d=%b t=%b ill=%b st=%b, want all 0",
               controlWord, k_mux, busy, done, taken, illegal, state);
    end
    tick();
    reset = 1'b0;
    status = 4'b0000;
    IR = IR_B; start = 1'b1;
    tick();
    start = 1'b0;
    checks++;
    if (state !== 4'b0001 || controlWord !== 36'h2 || k_mux !== 3'b011 || done !== 1'b1) begin
      errors++;
      $display("FAIL post_reset_b: got st=%b cw=%h k=%b d=%b, want 0001 2 011 1", state, controlWord, k_mux, done);
    end
    tick();
  endtask

  initial begin
    test_reset();
    test_b();
    test_bl();
    test_cbz_cbnz();
    test_br();
    test_bcond_sweep();
    test_illegal();
    test_back_to_back();
    test_reset_mid_cbz();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
